t_counter_ctrl: RTL and testbench



---
 rtl/t_counter_ctrl.sv | 120 ++++++++++++
 tb/tb_t_counter_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/t_counter_ctrl.sv
// Start/pause/stop/load sequencer for a bank of toggle cells forming an up/down counter.
// Every count change is applied as Q ^ T_VEC, so T_VEC is exactly the set of cells that flipped.
module t_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             UP,
  input  logic             CONT,
  input  logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] T_VEC,
  output logic [1:0]       STATE,
  output logic             BUSY,
  output logic             WRAP,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] tvec_q, tvec_d;
  logic [WIDTH-1:0] target_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, done_q;

  // The FSM only chooses a target count; the toggle vector is derived from it below.
  always_comb begin
    state_d  = state_q;
    target_d = q_q;
    wrap_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          target_d = LOAD_VAL;
        end else if (START && !STOP) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (STOP) begin
          state_d = S_PAUSE;
        end else if (UP) begin
          if (q_q >= MAX) begin
            if (CONT) begin
              target_d = '0;
              wrap_d   = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            target_d = q_q + 1'b1;
          end
        end else begin
          if (q_q == '0) begin
            if (CONT) begin
              target_d = MAX;
              wrap_d   = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            target_d = q_q - 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (START) begin
          state_d = S_RUN;
        end else if (LOAD) begin
          target_d = LOAD_VAL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tvec_d = q_q ^ target_d;

  // Status flags are computed from the next state so they line up with STATE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      tvec_q  <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_q ^ tvec_d;
      tvec_q  <= tvec_d;
      wrap_q  <= wrap_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_PAUSE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign Q     = q_q;
  assign T_VEC = tvec_q;
  assign STATE = state_q;
  assign BUSY  = busy_q;
  assign WRAP  = wrap_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_t_counter_ctrl.sv
// Bench for t_counter_ctrl: a counting model checked every cycle, directed scenarios
// with literal expectations, then a long randomized run.
module tb_t_counter_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       START = 1'b0, STOP = 1'b0, LOAD = 1'b0, UP = 1'b1, CONT = 1'b0;
  logic [3:0] LOAD_VAL = 4'd0, MAX = 4'd9;
  logic [3:0] Q, T_VEC;
  logic [1:0] STATE;
  logic       BUSY, WRAP, DONE;

  int  passCount = 0;
  int  totalCount = 0;
  bit  checking = 1'b0;

  int  mQ = 0, mT = 0, mSt = 0, mW = 0;

  t_counter_ctrl #(.WIDTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .UP(UP), .CONT(CONT), .MAX(MAX),
    .Q(Q), .T_VEC(T_VEC), .STATE(STATE), .BUSY(BUSY), .WRAP(WRAP), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    totalCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: the counter value as a plain integer; the toggle vector is just old ^ new.
  always @(posedge CLK or negedge RST_N) begin : refModel
    int nq, ns, w;
    if (!RST_N) begin
      mQ <= 0; mT <= 0; mSt <= 0; mW <= 0;
    end else begin
      nq = mQ; ns = mSt; w = 0;
      if (mSt == 0) begin
        if (LOAD) nq = int'(LOAD_VAL);
        else if (START && !STOP) ns = 1;
      end else if (mSt == 1) begin
        if (STOP) ns = 2;
        else if (UP && mQ >= int'(MAX)) begin
          if (CONT) begin nq = 0; w = 1; end else ns = 3;
        end else if (UP) nq = mQ + 1;
        else if (mQ == 0) begin
          if (CONT) begin nq = int'(MAX); w = 1; end else ns = 3;
        end else nq = mQ - 1;
      end else if (mSt == 2) begin
        if (STOP) ns = 0;
        else if (START) ns = 1;
        else if (LOAD) nq = int'(LOAD_VAL);
      end else begin
        ns = 0;
      end
      mQ <= nq; mT <= mQ ^ nq; mSt <= ns; mW <= w;
    end
  end

  always @(negedge CLK) begin
    if (checking) begin
      check("Q", int'(Q), mQ);
      check("T_VEC", int'(T_VEC), mT);
      check("STATE", int'(STATE), mSt);
      check("BUSY", int'(BUSY), int'(mSt == 1 || mSt == 2));
      check("WRAP", int'(WRAP), mW);
      check("DONE", int'(DONE), int'(mSt == 3));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic ld, input logic [3:0] lv);
    START = st; STOP = sp; LOAD = ld; LOAD_VAL = lv;
  endtask

  task automatic checkOutput(input string name, input int q, input int t, input int s, input int w, input int d);
    check({name, ".Q"}, int'(Q), q);
    check({name, ".T_VEC"}, int'(T_VEC), t);
    check({name, ".STATE"}, int'(STATE), s);
    check({name, ".WRAP"}, int'(WRAP), w);
    check({name, ".DONE"}, int'(DONE), d);
  endtask

  initial begin
    #1 RST_N = 1'b0;
    checking = 1'b1;
    cyc(2);
    RST_N = 1'b1;
    checkOutput("reset", 0, 0, 0, 0, 0);
    check("reset.BUSY", int'(BUSY), 0);

    // Reset mid-count
    MAX = 4'd9; CONT = 1'b0; UP = 1'b1;
    applyStimulus(1, 0, 0, 0); cyc();
    checkOutput("t1.start", 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); cyc(5);
    checkOutput("t1.q5", 5, 1, 1, 0, 0);
    #2 RST_N = 1'b0;
    #1 checkOutput("t1.asyncrst", 0, 0, 0, 0, 0);
    cyc();
    RST_N = 1'b1;

    // Single-shot up
    MAX = 4'd3;
    applyStimulus(1, 0, 0, 0); cyc();
    applyStimulus(0, 0, 0, 0);
    cyc(); checkOutput("t2.q1", 1, 1, 1, 0, 0);
    cyc(); checkOutput("t2.q2", 2, 3, 1, 0, 0);
    cyc(); checkOutput("t2.q3", 3, 1, 1, 0, 0);
    cyc(); checkOutput("t2.done", 3, 0, 3, 0, 1);
    cyc(); checkOutput("t2.idle", 3, 0, 0, 0, 0);
    check("t2.BUSY", int'(BUSY), 0);

    // Continuous wrap up, then down from zero
    MAX = 4'd5; CONT = 1'b1;
    applyStimulus(1, 0, 0, 0); cyc();
    applyStimulus(0, 0, 0, 0); cyc(2);
    checkOutput("t3.q5", 5, 1, 1, 0, 0);
    cyc(); checkOutput("t3.wrap", 0, 5, 1, 1, 0);
    cyc(); checkOutput("t3.after", 1, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0); cyc(2);
    applyStimulus(0, 0, 1, 0); cyc();
    UP = 1'b0;
    applyStimulus(1, 0, 0, 0); cyc();
    applyStimulus(0, 0, 0, 0); cyc();
    checkOutput("t3.downwrap", 5, 5, 1, 1, 0);
    applyStimulus(0, 1, 0, 0); cyc(2);

    // Pause, hold, load, resume
    UP = 1'b1; MAX = 4'd9; CONT = 1'b0;
    applyStimulus(0, 0, 1, 0); cyc();
    applyStimulus(1, 0, 0, 0); cyc();
    applyStimulus(0, 0, 0, 0); cyc(4);
    checkOutput("t4.q4", 4, 4'b0111, 1, 0, 0);
    applyStimulus(0, 1, 0, 0); cyc();
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); checkOutput("t4.hold", 4, 0, 2, 0, 0);
    end
    applyStimulus(0, 0, 1, 4'd7); cyc();
    checkOutput("t4.load", 7, 3, 2, 0, 0);
    applyStimulus(1, 0, 0, 0); cyc();
    applyStimulus(0, 0, 0, 0); cyc();
    checkOutput("t4.resume", 8, 15, 1, 0, 0);

    // Priority and preset above MAX
    applyStimulus(1, 1, 0, 0); cyc();
    checkOutput("t5.startstop", 8, 0, 2, 0, 0);
    applyStimulus(0, 1, 1, 4'd2); cyc();
    checkOutput("t5.stoplead", 8, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 4'd12); cyc();
    CONT = 1'b1;
    applyStimulus(1, 0, 0, 0); cyc();
    applyStimulus(0, 0, 0, 0); cyc();
    checkOutput("t5.abovemax", 0, 12, 1, 1, 0);

    // Down to zero and stop; LOAD ignored while running
    applyStimulus(0, 1, 0, 0); cyc(2);
    applyStimulus(0, 0, 1, 4'd2); cyc();
    UP = 1'b0; CONT = 1'b0;
    applyStimulus(1, 0, 0, 0); cyc();
    applyStimulus(0, 0, 1, 4'd9);
    cyc(); checkOutput("t6.q1", 1, 3, 1, 0, 0);
    cyc(); checkOutput("t6.q0", 0, 1, 1, 0, 0);
    cyc(); checkOutput("t6.done", 0, 0, 3, 0, 1);
    applyStimulus(0, 0, 0, 0);
    cyc(); checkOutput("t6.idle", 0, 0, 0, 0, 0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      START = ($urandom_range(0, 3) == 0);
      STOP = ($urandom_range(0, 9) == 0);
      LOAD = ($urandom_range(0, 7) == 0);
      LOAD_VAL = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) UP = ~UP;
      if ($urandom_range(0, 19) == 0) CONT = ~CONT;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0: MAX = 4'd0;
          1: MAX = 4'd15;
          2: MAX = 4'd1;
          default: MAX = 4'($urandom_range(0, 15));
        endcase
      end
      RST_N = ($urandom_range(0, 299) != 0);
      cyc();
    end
    RST_N = 1'b1;
    cyc(2);
    checking = 1'b0;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
